// File: rtl/credit_controller.sv
// Vending-machine credit front end: turns coin, vend and cancel pulses into
// registered up/down step commands for a downstream credit counter.
module credit_controller #(
  parameter int n          = 4,
  parameter int PRICE      = 3,
  parameter int MAX_CREDIT = 15
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         coin_nickel,
  input  logic         coin_dime,
  input  logic         vend_req,
  input  logic         cancel,
  output logic         UpDown,
  output logic         Inc,
  output logic         step_valid,
  output logic [n-1:0] credit,
  output logic         dispense,
  output logic         change_pulse,
  output logic         coin_reject,
  output logic         vend_denied,
  output logic         busy
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    VEND     = 2'd1,
    DISPENSE = 2'd2,
    RETURN   = 2'd3
  } state_t;

  localparam logic [n-1:0] PRICE_C = n'(PRICE);
  localparam logic [n:0]   MAX_C   = (n+1)'(MAX_CREDIT);

  state_t       state_r, state_s;
  logic [n-1:0] credit_r, credit_s;
  logic [n-1:0] remaining_r, remaining_s;
  logic         updown_r, updown_s;
  logic         inc_r, inc_s;
  logic         step_r, step_s;
  logic         dispense_r, dispense_s;
  logic         change_r, change_s;
  logic         reject_r, reject_s;
  logic         denied_r, denied_s;
  logic         busy_r;
  logic [n:0]   nickel_sum_s, dime_sum_s;

  assign nickel_sum_s = {1'b0, credit_r} + (n+1)'(1);
  assign dime_sum_s   = {1'b0, credit_r} + (n+1)'(2);

  // Next-state, next-credit and next-output decode
  always_comb begin
    state_s     = state_r;
    credit_s    = credit_r;
    remaining_s = remaining_r;
    updown_s    = 1'b0;
    inc_s       = 1'b0;
    step_s      = 1'b0;
    dispense_s  = 1'b0;
    change_s    = 1'b0;
    reject_s    = 1'b0;
    denied_s    = 1'b0;
    case (state_r)
      IDLE: begin
        // A cancel with no credit has nothing to return, so it does not mask other inputs
        if (cancel && (credit_r != n'(0))) begin
          state_s  = RETURN;
          reject_s = coin_nickel | coin_dime;
        end else if (vend_req) begin
          reject_s = coin_nickel | coin_dime;
          if (credit_r >= PRICE_C) begin
            state_s     = VEND;
            remaining_s = PRICE_C;
          end else begin
            denied_s = 1'b1;
          end
        end else if (coin_dime) begin
          if (dime_sum_s <= MAX_C) begin
            step_s   = 1'b1;
            inc_s    = 1'b1;
            credit_s = dime_sum_s[n-1:0];
            reject_s = coin_nickel;
          end else begin
            reject_s = 1'b1;
          end
        end else if (coin_nickel) begin
          if (nickel_sum_s <= MAX_C) begin
            step_s   = 1'b1;
            credit_s = nickel_sum_s[n-1:0];
          end else begin
            reject_s = 1'b1;
          end
        end else begin
          state_s = IDLE;
        end
      end
      VEND: begin
        reject_s = coin_nickel | coin_dime;
        step_s   = 1'b1;
        updown_s = 1'b1;
        if (remaining_r >= n'(2)) begin
          inc_s       = 1'b1;
          credit_s    = credit_r - n'(2);
          remaining_s = remaining_r - n'(2);
        end else begin
          credit_s    = credit_r - n'(1);
          remaining_s = remaining_r - n'(1);
        end
        if (remaining_s == n'(0)) begin
          state_s = DISPENSE;
        end else begin
          state_s = VEND;
        end
      end
      DISPENSE: begin
        reject_s   = coin_nickel | coin_dime;
        dispense_s = 1'b1;
        if (credit_r != n'(0)) begin
          state_s = RETURN;
        end else begin
          state_s = IDLE;
        end
      end
      RETURN: begin
        reject_s = coin_nickel | coin_dime;
        if (credit_r != n'(0)) begin
          step_s   = 1'b1;
          updown_s = 1'b1;
          change_s = 1'b1;
          credit_s = credit_r - n'(1);
          if (credit_s == n'(0)) begin
            state_s = IDLE;
          end else begin
            state_s = RETURN;
          end
        end else begin
          state_s = IDLE;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State, credit mirror and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= IDLE;
      credit_r    <= '0;
      remaining_r <= '0;
      updown_r    <= 1'b0;
      inc_r       <= 1'b0;
      step_r      <= 1'b0;
      dispense_r  <= 1'b0;
      change_r    <= 1'b0;
      reject_r    <= 1'b0;
      denied_r    <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      credit_r    <= credit_s;
      remaining_r <= remaining_s;
      updown_r    <= updown_s;
      inc_r       <= inc_s;
      step_r      <= step_s;
      dispense_r  <= dispense_s;
      change_r    <= change_s;
      reject_r    <= reject_s;
      denied_r    <= denied_s;
      busy_r      <= (state_s != IDLE);
    end
  end

  assign UpDown       = updown_r;
  assign Inc          = inc_r;
  assign step_valid   = step_r;
  assign credit       = credit_r;
  assign dispense     = dispense_r;
  assign change_pulse = change_r;
  assign coin_reject  = reject_r;
  assign vend_denied  = denied_r;
  assign busy         = busy_r;

endmodule

// File: tb/tb_credit_controller.sv
// Scoreboard bench for credit_controller: directed pulses push hand-computed
// output events; a negedge monitor pops and compares each event the DUT shows.
module tb_credit_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       coin_nickel = 1'b0, coin_dime = 1'b0, vend_req = 1'b0, cancel = 1'b0;
  logic       UpDown, Inc, step_valid, dispense, change_pulse, coin_reject, vend_denied, busy;
  logic [3:0] credit;

  int vectors = 0;
  int miscompares = 0;
  logic [10:0] exp_q[$];

  credit_controller #(.n(4), .PRICE(3), .MAX_CREDIT(15)) dut (
    .clk(clk), .reset(reset),
    .coin_nickel(coin_nickel), .coin_dime(coin_dime),
    .vend_req(vend_req), .cancel(cancel),
    .UpDown(UpDown), .Inc(Inc), .step_valid(step_valid), .credit(credit),
    .dispense(dispense), .change_pulse(change_pulse), .coin_reject(coin_reject),
    .vend_denied(vend_denied), .busy(busy)
  );

  always #5 clk = ~clk;

  // Event layout: {step_valid, UpDown, Inc, dispense, change_pulse, coin_reject, vend_denied, credit}
  function automatic logic [10:0] ev(input logic sv, ud, inc, d, c, r, v, input logic [3:0] cr);
    return {sv, ud, inc, d, c, r, v, cr};
  endfunction

  function automatic logic [10:0] snap();
    return {step_valid, UpDown, Inc, dispense, change_pulse, coin_reject, vend_denied, credit};
  endfunction

  // Monitor: every cycle with an active pulse output is one scoreboard event
  always @(negedge clk) begin
    if (!reset && (step_valid || dispense || change_pulse || coin_reject || vend_denied)) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_event: got %b, required no event", snap());
      end else begin
        logic [10:0] e;
        e = exp_q.pop_front();
        if (snap() !== e) begin
          miscompares++;
          $display("FAIL event: got %b, required %b (sv ud inc disp chg rej den credit)", snap(), e);
        end
      end
    end
  end

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] req);
    vectors++;
    if (got !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h, required %0h", name, got, req);
    end
  endtask

  task automatic pulse(input logic n, d, v, c);
    coin_nickel = n; coin_dime = d; vend_req = v; cancel = c;
    @(posedge clk); #1;
    coin_nickel = 1'b0; coin_dime = 1'b0; vend_req = 1'b0; cancel = 1'b0;
  endtask

  task automatic drain(input string name);
    int k;
    for (k = 0; k < 60 && (exp_q.size() != 0 || busy); k++) @(negedge clk);
    if (exp_q.size() != 0 || busy) begin
      vectors++;
      miscompares++;
      $display("FAIL %s_timeout: got %0d pending events busy=%b, required 0 pending busy=0", name, exp_q.size(), busy);
      exp_q.delete();
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #12;
    check("reset_outputs", {4'h0, snap(), busy}, 16'h0000);
    #10 reset = 1'b0;
    @(posedge clk); #1;

    // PRICE=3: dime, dime, vend -> +2,+2,-2,-1, dispense, one change
    exp_q.push_back(ev(1, 0, 1, 0, 0, 0, 0, 4'd2)); pulse(0, 1, 0, 0);
    exp_q.push_back(ev(1, 0, 1, 0, 0, 0, 0, 4'd4)); pulse(0, 1, 0, 0);
    exp_q.push_back(ev(1, 1, 1, 0, 0, 0, 0, 4'd2));
    exp_q.push_back(ev(1, 1, 0, 0, 0, 0, 0, 4'd1));
    exp_q.push_back(ev(0, 0, 0, 1, 0, 0, 0, 4'd1));
    exp_q.push_back(ev(1, 1, 0, 0, 1, 0, 0, 4'd0));
    pulse(0, 0, 1, 0);
    drain("vend");
    check("vend_credit", {12'h0, credit}, 16'd0);

    // Nickel and dime together: dime taken, nickel rejected
    exp_q.push_back(ev(1, 0, 1, 0, 0, 1, 0, 4'd2)); pulse(1, 1, 0, 0);
    drain("both_coins");
    check("both_credit", {12'h0, credit}, 16'd2);

    // Vend with insufficient credit
    exp_q.push_back(ev(0, 0, 0, 0, 0, 0, 1, 4'd2)); pulse(0, 0, 1, 0);
    @(negedge clk);
    check("denied_busy", {15'h0, busy}, 16'd0);
    drain("denied");

    // Fill to 14, overflowing dime rejected, nickel reaches 15, next nickel rejected
    for (int i = 0; i < 6; i++) begin
      exp_q.push_back(ev(1, 0, 1, 0, 0, 0, 0, 4'(4 + 2 * i)));
      pulse(0, 1, 0, 0);
    end
    exp_q.push_back(ev(0, 0, 0, 0, 0, 1, 0, 4'd14)); pulse(0, 1, 0, 0);
    exp_q.push_back(ev(1, 0, 0, 0, 0, 0, 0, 4'd15)); pulse(1, 0, 0, 0);
    exp_q.push_back(ev(0, 0, 0, 0, 0, 1, 0, 4'd15)); pulse(1, 0, 0, 0);
    drain("fill");
    check("full_credit", {12'h0, credit}, 16'd15);

    // Cancel at full credit; a nickel during RETURN is rejected alongside the first change
    exp_q.push_back(ev(1, 1, 0, 0, 1, 1, 0, 4'd14));
    for (int c = 13; c >= 0; c--) exp_q.push_back(ev(1, 1, 0, 0, 1, 0, 0, 4'(c)));
    pulse(0, 0, 0, 1);
    pulse(1, 0, 0, 0);
    drain("cancel_full");
    check("cancel_credit", {12'h0, credit}, 16'd0);

    // credit=3, cancel+vend_req together: three changes, no dispense
    exp_q.push_back(ev(1, 0, 0, 0, 0, 0, 0, 4'd1)); pulse(1, 0, 0, 0);
    exp_q.push_back(ev(1, 0, 1, 0, 0, 0, 0, 4'd3)); pulse(0, 1, 0, 0);
    for (int c = 2; c >= 0; c--) exp_q.push_back(ev(1, 1, 0, 0, 1, 0, 0, 4'(c)));
    pulse(0, 0, 1, 1);
    drain("cancel_vend");

    // Reset while returning change
    exp_q.push_back(ev(1, 0, 1, 0, 0, 0, 0, 4'd2)); pulse(0, 1, 0, 0);
    exp_q.push_back(ev(1, 0, 1, 0, 0, 0, 0, 4'd4)); pulse(0, 1, 0, 0);
    for (int c = 3; c >= 0; c--) exp_q.push_back(ev(1, 1, 0, 0, 1, 0, 0, 4'(c)));
    pulse(0, 0, 0, 1);
    @(posedge clk);
    @(negedge clk);
    check("busy_in_return", {15'h0, busy}, 16'd1);
    #2 reset = 1'b1;
    #1;
    check("async_reset_outputs", {4'h0, snap(), busy}, 16'h0000);
    exp_q.delete();
    #10 reset = 1'b0;
    @(posedge clk); #1;
    exp_q.push_back(ev(1, 0, 0, 0, 0, 0, 0, 4'd1)); pulse(1, 0, 0, 0);
    drain("after_reset");
    check("after_reset_credit", {12'h0, credit}, 16'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
